rvga_mem_arbiter: RTL and testbench

//  Two-client memory arbiter directly upstream of the DDR/memory model port
//  (r_v/w_v/addr/data/resp_v). Merges the core's instruction-fetch port (read-only)
//  and data port (read/write) onto the single memory port.
//  One transaction in flight; round-robin between clients; optional response timeout.

---
 rtl/rvga_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_rvga_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvga_mem_arbiter.sv
// Two-client (fetch / data) arbiter in front of a single-outstanding memory port.
// Round-robin on contention, one transaction in flight, optional response timeout.
module rvga_mem_arbiter #(
  parameter int timeout_p = 64,
  parameter int debug_p   = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_r_v_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  output logic        imem_resp_v_o,
  input  logic        dmem_r_v_i,
  input  logic        dmem_w_v_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  output logic [31:0] dmem_data_o,
  output logic        dmem_resp_v_o,
  output logic        mem_r_v_o,
  output logic        mem_w_v_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_resp_v_i,
  output logic        timeout_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic CL_IMEM = 1'b0;
  localparam logic CL_DMEM = 1'b1;

  localparam int            TW    = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [TW-1:0] TLIM  = (timeout_p > 0) ? TW'(timeout_p - 1) : '0;
  localparam bit            TO_EN = (timeout_p > 0);

  logic [1:0]    state_q, state_d;
  logic          client_q, client_d;   // granted client, doubles as last_grant
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          to_q, to_d;
  logic          dmem_req;
  logic          pick;

  always_comb begin
    state_d  = state_q;
    client_d = client_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    timer_d  = timer_q;
    to_d     = to_q;
    pick     = CL_IMEM;
    dmem_req = dmem_r_v_i | dmem_w_v_i;

    case (state_q)
      IDLE: begin
        to_d = 1'b0;
        if (imem_r_v_i || dmem_req) begin
          // On contention the client that did not win last time goes first
          if (imem_r_v_i && dmem_req) pick = ~client_q;
          else                        pick = dmem_req ? CL_DMEM : CL_IMEM;
          client_d = pick;
          timer_d  = '0;
          state_d  = GRANT;
          if (pick == CL_DMEM) begin
            we_d    = dmem_w_v_i;
            addr_d  = dmem_addr_i;
            wdata_d = dmem_data_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = imem_addr_i;
            wdata_d = '0;
          end
        end
      end
      GRANT: begin
        if (mem_resp_v_i) begin
          rdata_d = we_q ? 32'h0 : mem_data_i;
          timer_d = '0;
          state_d = RESP;
        end else if (TO_EN && (timer_q == TLIM)) begin
          rdata_d = 32'hDEADBEEF;
          to_d    = 1'b1;
          timer_d = '0;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      client_q <= CL_IMEM;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      timer_q  <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      client_q <= client_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      timer_q  <= timer_d;
      to_q     <= to_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once
  assign mem_r_v_o     = (state_q == GRANT) && !we_q;
  assign mem_w_v_o     = (state_q == GRANT) && we_q;
  assign mem_addr_o    = addr_q;
  assign mem_data_o    = wdata_q;
  assign imem_resp_v_o = (state_q == RESP) && (client_q == CL_IMEM);
  assign dmem_resp_v_o = (state_q == RESP) && (client_q == CL_DMEM);
  assign imem_data_o   = imem_resp_v_o ? rdata_q : 32'h0;
  assign dmem_data_o   = dmem_resp_v_o ? rdata_q : 32'h0;
  assign timeout_o     = (state_q == RESP) && to_q;

  generate
    if (debug_p != 0) begin : g_debug
      // Simultaneous read and write on the data port is illegal; write wins
      always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == IDLE) begin
          assert (!(dmem_r_v_i && dmem_w_v_i));
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Directed bench for rvga_mem_arbiter: vector table of single transactions plus
// contention, timeout and mid-transaction reset sequences against a combinational memory.
module tb_rvga_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_r_v;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_resp;
  logic        dmem_r_v;
  logic        dmem_w_v;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_data;
  logic        dmem_resp;
  logic        mem_r_v;
  logic        mem_w_v;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        timeout;
  logic        mem_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rvga_mem_arbiter #(.timeout_p(4), .debug_p(0)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_r_v_i    (imem_r_v),
    .imem_addr_i   (imem_addr),
    .imem_data_o   (imem_data),
    .imem_resp_v_o (imem_resp),
    .dmem_r_v_i    (dmem_r_v),
    .dmem_w_v_i    (dmem_w_v),
    .dmem_addr_i   (dmem_addr),
    .dmem_data_i   (dmem_wdata),
    .dmem_data_o   (dmem_data),
    .dmem_resp_v_o (dmem_resp),
    .mem_r_v_o     (mem_r_v),
    .mem_w_v_o     (mem_w_v),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_wdata),
    .mem_data_i    (mem_rdata),
    .mem_resp_v_i  (mem_resp),
    .timeout_o     (timeout)
  );

  // Combinational-response memory, reloaded with a known pattern while reset is held
  logic [31:0] mem_arr [256];
  assign mem_resp  = (mem_r_v || mem_w_v) && !mem_stall;
  assign mem_rdata = mem_r_v ? mem_arr[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h1000_0000 | i;
      mem_arr[4] <= 32'h0000_0013;
    end else if (mem_w_v && !mem_stall) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    imem_r_v = 1'b0;
    dmem_r_v = 1'b0;
    dmem_w_v = 1'b0;
  endtask

  typedef struct {
    logic        dmem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic run_txn(input int idx, input vec_t v);
    string p;
    p = $sformatf("vec%0d", idx);
    if (v.dmem) begin
      dmem_r_v   = !v.we;
      dmem_w_v   = v.we;
      dmem_addr  = v.addr;
      dmem_wdata = v.wdata;
    end else begin
      imem_r_v  = 1'b1;
      imem_addr = v.addr;
    end
    step();
    chk1({p, " mem_r_v"}, mem_r_v, !v.we);
    chk1({p, " mem_w_v"}, mem_w_v, v.we);
    chk32({p, " mem_addr"}, mem_addr, v.addr);
    if (v.we) chk32({p, " mem_data"}, mem_wdata, v.wdata);
    chk1({p, " early_resp"}, imem_resp | dmem_resp, 1'b0);
    step();
    chk1({p, " imem_resp"}, imem_resp, !v.dmem);
    chk1({p, " dmem_resp"}, dmem_resp, v.dmem);
    chk32({p, " imem_data"}, imem_data, v.dmem ? 32'h0 : v.rdata);
    chk32({p, " dmem_data"}, dmem_data, v.dmem ? v.rdata : 32'h0);
    chk1({p, " strobes_in_resp"}, mem_r_v | mem_w_v, 1'b0);
    $display("txn %0d client=%s we=%0d addr=%h resp_data=%h", idx,
             v.dmem ? "dmem" : "imem", v.we, v.addr, v.dmem ? dmem_data : imem_data);
    drop_reqs();
    step();
    chk1({p, " idle_no_resp"}, imem_resp | dmem_resp, 1'b0);
  endtask

  // Both clients hold reads (dmem 0x08, imem 0x10): DMEM, IMEM, DMEM, IMEM, one every 3 cycles
  task automatic run_both(input string tag, input logic [31:0] d_exp, input logic [31:0] i_exp);
    logic ed, ei;
    imem_r_v  = 1'b1;
    imem_addr = 32'h10;
    dmem_r_v  = 1'b1;
    dmem_addr = 32'h08;
    for (int c = 1; c <= 12; c++) begin
      step();
      ed = (c == 2) || (c == 8);
      ei = (c == 5) || (c == 11);
      chk1($sformatf("%s c%0d dmem_resp", tag, c), dmem_resp, ed);
      chk1($sformatf("%s c%0d imem_resp", tag, c), imem_resp, ei);
      chk32($sformatf("%s c%0d dmem_data", tag, c), dmem_data, ed ? d_exp : 32'h0);
      chk32($sformatf("%s c%0d imem_data", tag, c), imem_data, ei ? i_exp : 32'h0);
      chk1($sformatf("%s c%0d strobe_excl", tag, c), mem_r_v & mem_w_v, 1'b0);
      if (ed || ei)
        $display("txn %s cycle=%0d client=%s data=%h", tag, c, ed ? "dmem" : "imem",
                 ed ? dmem_data : imem_data);
    end
    drop_reqs();
  endtask

  initial begin
    vecs[0] = '{dmem: 1'b0, we: 1'b0, addr: 32'h10,  wdata: 32'h0,        rdata: 32'h0000_0013};
    vecs[1] = '{dmem: 1'b1, we: 1'b1, addr: 32'h100, wdata: 32'hCAFEF00D, rdata: 32'h0};
    vecs[2] = '{dmem: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0,        rdata: 32'hCAFEF00D};
    vecs[3] = '{dmem: 1'b0, we: 1'b0, addr: 32'h100, wdata: 32'h0,        rdata: 32'hCAFEF00D};
    vecs[4] = '{dmem: 1'b1, we: 1'b1, addr: 32'h24,  wdata: 32'h12345678, rdata: 32'h0};
    vecs[5] = '{dmem: 1'b0, we: 1'b0, addr: 32'h24,  wdata: 32'h0,        rdata: 32'h12345678};
    vecs[6] = '{dmem: 1'b1, we: 1'b0, addr: 32'h08,  wdata: 32'h0,        rdata: 32'h1000_0002};

    rst        = 1'b1;
    mem_stall  = 1'b0;
    imem_r_v   = 1'b0;
    imem_addr  = 32'h0;
    dmem_r_v   = 1'b0;
    dmem_w_v   = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;

    step();
    step();
    chk1("rst mem_r_v", mem_r_v, 1'b0);
    chk1("rst mem_w_v", mem_w_v, 1'b0);
    chk32("rst mem_addr", mem_addr, 32'h0);
    chk32("rst mem_data", mem_wdata, 32'h0);
    chk1("rst imem_resp", imem_resp, 1'b0);
    chk1("rst dmem_resp", dmem_resp, 1'b0);
    chk32("rst imem_data", imem_data, 32'h0);
    chk32("rst dmem_data", dmem_data, 32'h0);
    chk1("rst timeout", timeout, 1'b0);
    #2 rst = 1'b0;

    // Contention straight out of reset
    run_both("rr", 32'h1000_0002, 32'h0000_0013);

    foreach (vecs[i]) run_txn(i, vecs[i]);

    // Timeout: 4 GRANT cycles, then response with DEADBEEF and timeout pulse together
    mem_stall = 1'b1;
    imem_r_v  = 1'b1;
    imem_addr = 32'h40;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk1($sformatf("to c%0d mem_r_v", c), mem_r_v, 1'b1);
      chk1($sformatf("to c%0d imem_resp", c), imem_resp, 1'b0);
      chk1($sformatf("to c%0d timeout", c), timeout, 1'b0);
    end
    step();
    chk1("to imem_resp", imem_resp, 1'b1);
    chk32("to imem_data", imem_data, 32'hDEADBEEF);
    chk1("to timeout", timeout, 1'b1);
    chk1("to dmem_resp", dmem_resp, 1'b0);
    chk1("to strobe_off", mem_r_v, 1'b0);
    $display("txn timeout client=imem addr=%h resp_data=%h timeout=%0d", imem_addr, imem_data, timeout);
    drop_reqs();
    mem_stall = 1'b0;
    step();
    chk1("to pulse_ends", timeout, 1'b0);

    // Reset while a stalled write is in GRANT
    mem_stall  = 1'b1;
    dmem_w_v   = 1'b1;
    dmem_addr  = 32'h80;
    dmem_wdata = 32'h55AA55AA;
    step();
    chk1("mid mem_w_v", mem_w_v, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("mid rst mem_w_v", mem_w_v, 1'b0);
    chk1("mid rst mem_r_v", mem_r_v, 1'b0);
    chk1("mid rst dmem_resp", dmem_resp, 1'b0);
    chk32("mid rst mem_addr", mem_addr, 32'h0);
    drop_reqs();
    mem_stall = 1'b0;
    step();
    #2 rst = 1'b0;
    step();
    chk1("post rst no_resp", dmem_resp | imem_resp, 1'b0);
    $display("txn reset_abort client=dmem addr=00000080 delivered=0");

    // Served normally after reset, arbitration restarted from IMEM as last grant
    run_both("post", 32'h1000_0002, 32'h0000_0013);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
